// File: rtl/merge_pkg.sv
// rtl/merge_pkg.sv - split-stage state encoding, frame count and {ch, th, low} field helpers
package merge_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_GAP  = 2'd1,
        ST_TAIL = 2'd2
    } split_state_t;

    // Wide enough for any extended triple; callers size-cast the results back down.
    localparam int FIELD_W = 128;

    // Number of sub-frames per super-frame.
    function automatic int frames(input int thw);
        return 1 << thw;
    endfunction

    function automatic logic [FIELD_W-1:0] field_mask(input int n);
        return (FIELD_W'(1) << n) - FIELD_W'(1);
    endfunction

    // Extended triple layout: {ch[sw], th[thw], low[dw-sw]}.
    function automatic logic [FIELD_W-1:0] ext_low(input logic [FIELD_W-1:0] d, input int dw, input int sw);
        return d & field_mask(dw - sw);
    endfunction

    function automatic logic [FIELD_W-1:0] ext_th(input logic [FIELD_W-1:0] d, input int dw, input int sw,
                                                   input int thw);
        return (d >> (dw - sw)) & field_mask(thw);
    endfunction

    function automatic logic [FIELD_W-1:0] ext_ch(input logic [FIELD_W-1:0] d, input int dw, input int sw,
                                                   input int thw);
        return (d >> (dw - sw + thw)) & field_mask(sw);
    endfunction

endpackage

// File: rtl/merge_split_hold.sv
// rtl/merge_split_hold.sv - one-entry hold register for the split stage; load wins over clear
module merge_split_hold #(
    parameter int DW  = 32,
    parameter int THW = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           clear,
    input  logic [DW-1:0]  d_data,
    input  logic [THW-1:0] d_th,
    input  logic           d_last,
    input  logic           d_empty,
    output logic [DW-1:0]  q_data,
    output logic [THW-1:0] q_th,
    output logic           q_last,
    output logic           q_empty,
    output logic           q_vld
);

    // Capture a beat on load; clear only drops the valid flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_data  <= '0;
            q_th    <= '0;
            q_last  <= 1'b0;
            q_empty <= 1'b0;
            q_vld   <= 1'b0;
        end else if (load) begin
            q_data  <= d_data;
            q_th    <= d_th;
            q_last  <= d_last;
            q_empty <= d_empty;
            q_vld   <= 1'b1;
        end else if (clear) begin
            q_vld   <= 1'b0;
        end
    end

endmodule

// File: rtl/merge_split.sv
// rtl/merge_split.sv - re-emits a merged super-frame as 2^THW sub-frames; MERGE_SPLIT_ORDER_CHK_EN adds the th order checker
module merge_split
    import merge_pkg::*;
#(
    parameter int DW  = 32,
    parameter int SW  = 8,
    parameter int THW = 6
) (
    input  logic              clk,
    input  logic              reset,
    output logic              i_ready,
    input  logic              i_valid,
    input  logic              i_last,
    input  logic              i_empty,
    input  logic [DW+THW-1:0] i_data,
    input  logic              o_ready,
    output logic              o_valid,
    output logic              o_last,
    output logic              o_empty,
    output logic [DW-1:0]     o_data,
    output logic [THW-1:0]    o_th,
    output logic              o_err
);

    localparam int             LW     = DW - SW;
    localparam logic [THW-1:0] TH_MAX = THW'(frames(THW) - 1);

    split_state_t   state;
    logic [THW-1:0] cur;
    logic [THW-1:0] cur_inc;

    logic [DW-1:0]  in_dl;
    logic [THW-1:0] in_th_raw;
    logic [THW-1:0] in_th;
    logic [THW:0]   th_next;
    logic           gap_ahead;
    logic           in_fire;
    logic           out_fire;
    logic           hold_load;
    logic           hold_clear;

    logic [DW-1:0]  hold_data;
    logic [THW-1:0] hold_th;
    logic           hold_last;
    logic           hold_empty;
    logic           hold_vld;

    assign in_dl     = {SW'(ext_ch(FIELD_W'(i_data), DW, SW, THW)), LW'(ext_low(FIELD_W'(i_data), DW, SW))};
    assign in_th_raw = THW'(ext_th(FIELD_W'(i_data), DW, SW, THW));

`ifdef MERGE_SPLIT_ORDER_CHK_EN
    logic order_bad;
    logic err_q;

    // A backwards th on a follow-on beat is folded into the current sub-frame.
    assign order_bad = hold_vld && !hold_last && (in_th_raw < hold_th);
    assign in_th     = order_bad ? hold_th : in_th_raw;

    // Sticky until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (in_fire && order_bad) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign in_th = in_th_raw;
    assign o_err = 1'b0;
`endif

    // One bit wider so th_max+1 does not wrap in the gap test.
    assign th_next   = {1'b0, hold_th} + {{THW{1'b0}}, 1'b1};
    assign gap_ahead = {1'b0, in_th} > th_next;
    assign cur_inc   = cur + THW'(1);

    assign in_fire    = i_valid && i_ready;
    assign out_fire   = o_valid && o_ready;
    // An empty super-frame marker carries no triple, so it never occupies the hold.
    assign hold_load  = in_fire && (hold_vld || !(i_empty && i_last));
    assign hold_clear = (state == ST_RUN) && hold_vld && hold_last && out_fire;

    merge_split_hold #(
        .DW  (DW),
        .THW (THW)
    ) u_hold (
        .clk     (clk),
        .reset   (reset),
        .load    (hold_load),
        .clear   (hold_clear),
        .d_data  (in_dl),
        .d_th    (in_th),
        .d_last  (i_last),
        .d_empty (i_empty),
        .q_data  (hold_data),
        .q_th    (hold_th),
        .q_last  (hold_last),
        .q_empty (hold_empty),
        .q_vld   (hold_vld)
    );

    // Output decode: a held triple waits for its successor so o_last can be known.
    always_comb begin
        i_ready = 1'b0;
        o_valid = 1'b0;
        o_last  = 1'b0;
        o_empty = 1'b0;
        o_data  = '0;
        o_th    = cur;
        case (state)
            ST_RUN: begin
                if (!hold_vld) begin
                    i_ready = 1'b1;
                end else if (!hold_last) begin
                    o_valid = i_valid;
                    o_last  = (in_th != hold_th);
                    o_empty = hold_empty;
                    o_data  = hold_empty ? '0 : hold_data;
                    o_th    = hold_th;
                    i_ready = o_ready;
                end else begin
                    o_valid = 1'b1;
                    o_last  = 1'b1;
                    o_empty = hold_empty;
                    o_data  = hold_empty ? '0 : hold_data;
                    o_th    = hold_th;
                end
            end
            ST_GAP, ST_TAIL: begin
                o_valid = 1'b1;
                o_empty = 1'b1;
                o_last  = 1'b1;
            end
            default: ;
        endcase
    end

    // Sub-frame sequencer: tracks the next expected th and inserts placeholders.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            cur   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!hold_vld) begin
                        if (in_fire) begin
                            if (i_empty && i_last) begin
                                state <= ST_TAIL;
                                cur   <= '0;
                            end else if (in_th != cur) begin
                                state <= ST_GAP;
                            end
                        end
                    end else if (!hold_last) begin
                        if (out_fire) begin
                            if (gap_ahead) begin
                                state <= ST_GAP;
                                cur   <= th_next[THW-1:0];
                            end else begin
                                cur   <= in_th;
                            end
                        end
                    end else if (out_fire) begin
                        if (hold_th == TH_MAX) begin
                            cur   <= '0;
                        end else begin
                            state <= ST_TAIL;
                            cur   <= th_next[THW-1:0];
                        end
                    end
                end
                ST_GAP: begin
                    if (out_fire) begin
                        cur <= cur_inc;
                        if (cur_inc == hold_th) begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_TAIL: begin
                    if (out_fire) begin
                        cur <= cur_inc;
                        if (cur == TH_MAX) begin
                            state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    state <= ST_RUN;
                    cur   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_merge_split.sv
// tb/tb_merge_split.sv - directed bench for merge_split at DW=16, SW=4, THW=2
module tb_merge_split;

    localparam int DW  = 16;
    localparam int SW  = 4;
    localparam int THW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              i_ready;
    logic              i_valid = 1'b0;
    logic              i_last = 1'b0;
    logic              i_empty = 1'b0;
    logic [DW+THW-1:0] i_data = '0;
    logic              o_ready = 1'b1;
    logic              o_valid;
    logic              o_last;
    logic              o_empty;
    logic [DW-1:0]     o_data;
    logic [THW-1:0]    o_th;
    logic              o_err;

    int n_vec = 0;
    int n_bad = 0;

    logic [19:0] in_q[$];
    logic [19:0] exp_q[$];

    merge_split #(
        .DW  (DW),
        .SW  (SW),
        .THW (THW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_ready (i_ready),
        .i_valid (i_valid),
        .i_last  (i_last),
        .i_empty (i_empty),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_last  (o_last),
        .o_empty (o_empty),
        .o_data  (o_data),
        .o_th    (o_th),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    // Input entry: {last, empty, ch, th, low}
    function automatic logic [19:0] mk_in(input logic [3:0] ch, input logic [1:0] th, input logic [11:0] low,
                                          input logic last);
        return {last, 1'b0, ch, th, low};
    endfunction

    // Expected beat: {empty, last, th, ch, low}
    function automatic logic [19:0] mk_dat(input logic [3:0] ch, input logic [1:0] th, input logic [11:0] low,
                                           input logic last);
        return {1'b0, last, th, ch, low};
    endfunction

    function automatic logic [19:0] mk_emp(input logic [1:0] th);
        return {2'b11, th, 16'h0000};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic run(input string tag, input bit toggle, input bit check_beats);
        bit          stalled = 1'b0;
        bit          acc;
        logic [20:0] prev = '0;
        logic [20:0] now;
        for (int c = 0; c < 40; c++) begin
            if (in_q.size() > 0) begin
                i_valid = 1'b1;
                {i_last, i_empty, i_data} = in_q[0];
            end else begin
                i_valid = 1'b0;
                i_last  = 1'b0;
                i_empty = 1'b0;
                i_data  = '0;
            end
            o_ready = !toggle || (c % 2 == 0);
            #1;
            now = {o_valid, o_last, o_empty, o_th, o_data};
            if (stalled) chk({tag, " stall"}, 32'(now), 32'(prev));
            if (o_valid && o_empty) chk({tag, " i_ready_in_empty"}, 32'(i_ready), 32'd0);
            if (check_beats && o_valid && o_ready) begin
                if (exp_q.size() == 0) chk({tag, " extra_beat"}, 32'(now), 32'd0);
                else chk({tag, " beat"}, 32'({o_empty, o_last, o_th, o_data}), 32'(exp_q.pop_front()));
            end
            stalled = o_valid && !o_ready;
            prev    = now;
            acc     = i_valid && i_ready;
            @(posedge clk);
            #1;
            if (acc) void'(in_q.pop_front());
        end
        if (check_beats) chk({tag, " beats_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, " inputs_left"}, 32'(in_q.size()), 32'd0);
        chk({tag, " idle_o_valid"}, 32'(o_valid), 32'd0);
        chk({tag, " idle_i_ready"}, 32'(i_ready), 32'd1);
        exp_q.delete();
        in_q.delete();
    endtask

    initial begin
        #3;
        chk("rst o_valid", 32'(o_valid), 32'd0);
        chk("rst o_last", 32'(o_last), 32'd0);
        chk("rst o_empty", 32'(o_empty), 32'd0);
        chk("rst o_data", 32'(o_data), 32'd0);
        chk("rst o_th", 32'(o_th), 32'd0);
        chk("rst o_err", 32'(o_err), 32'd0);
        #9;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // th 0,0,1,2,3: all data, sub-frame boundaries on beats 2..5
        in_q  = {mk_in(4'h1, 2'd0, 12'h101, 1'b0), mk_in(4'h2, 2'd0, 12'h202, 1'b0),
                 mk_in(4'h3, 2'd1, 12'h303, 1'b0), mk_in(4'h4, 2'd2, 12'h404, 1'b0),
                 mk_in(4'h5, 2'd3, 12'h505, 1'b1)};
        exp_q = {mk_dat(4'h1, 2'd0, 12'h101, 1'b0), mk_dat(4'h2, 2'd0, 12'h202, 1'b1),
                 mk_dat(4'h3, 2'd1, 12'h303, 1'b1), mk_dat(4'h4, 2'd2, 12'h404, 1'b1),
                 mk_dat(4'h5, 2'd3, 12'h505, 1'b1)};
        run("s1", 1'b0, 1'b1);

        // single triple in sub-frame 2
        in_q  = {mk_in(4'hC, 2'd2, 12'hABC, 1'b1)};
        exp_q = {mk_emp(2'd0), mk_emp(2'd1), mk_dat(4'hC, 2'd2, 12'hABC, 1'b1), mk_emp(2'd3)};
        run("s2", 1'b0, 1'b1);

        // reset while placeholders are pending drops everything
        o_ready = 1'b0;
        i_valid = 1'b1;
        {i_last, i_empty, i_data} = mk_in(4'h9, 2'd1, 12'h999, 1'b0);
        #1;
        chk("mid accept", 32'(i_ready), 32'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        #1;
        chk("mid gap o_valid", 32'(o_valid), 32'd1);
        chk("mid gap o_empty", 32'(o_empty), 32'd1);
        chk("mid gap o_th", 32'(o_th), 32'd0);
        reset = 1'b0;
        #1;
        chk("mid rst o_valid", 32'(o_valid), 32'd0);
        chk("mid rst i_ready", 32'(i_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // empty super-frame: i_data ignored, four placeholders
        in_q  = {{2'b11, 18'h2ABCD}};
        exp_q = {mk_emp(2'd0), mk_emp(2'd1), mk_emp(2'd2), mk_emp(2'd3)};
        run("s3", 1'b0, 1'b1);

        // th 0,3: two placeholders in the middle
        in_q  = {mk_in(4'h7, 2'd0, 12'h070, 1'b0), mk_in(4'h8, 2'd3, 12'h083, 1'b1)};
        exp_q = {mk_dat(4'h7, 2'd0, 12'h070, 1'b1), mk_emp(2'd1), mk_emp(2'd2),
                 mk_dat(4'h8, 2'd3, 12'h083, 1'b1)};
        run("s4", 1'b0, 1'b1);

        // scenario 1 again with o_ready toggling
        in_q  = {mk_in(4'h1, 2'd0, 12'h101, 1'b0), mk_in(4'h2, 2'd0, 12'h202, 1'b0),
                 mk_in(4'h3, 2'd1, 12'h303, 1'b0), mk_in(4'h4, 2'd2, 12'h404, 1'b0),
                 mk_in(4'h5, 2'd3, 12'h505, 1'b1)};
        exp_q = {mk_dat(4'h1, 2'd0, 12'h101, 1'b0), mk_dat(4'h2, 2'd0, 12'h202, 1'b1),
                 mk_dat(4'h3, 2'd1, 12'h303, 1'b1), mk_dat(4'h4, 2'd2, 12'h404, 1'b1),
                 mk_dat(4'h5, 2'd3, 12'h505, 1'b1)};
        run("s5", 1'b1, 1'b1);

        // out-of-order th 2,1
        chk("err before", 32'(o_err), 32'd0);
        in_q = {mk_in(4'h6, 2'd2, 12'h606, 1'b0), mk_in(4'h7, 2'd1, 12'h707, 1'b1)};
`ifdef MERGE_SPLIT_ORDER_CHK_EN
        exp_q = {mk_emp(2'd0), mk_emp(2'd1), mk_dat(4'h6, 2'd2, 12'h606, 1'b0),
                 mk_dat(4'h7, 2'd2, 12'h707, 1'b1), mk_emp(2'd3)};
        run("s6", 1'b0, 1'b1);
        chk("err set", 32'(o_err), 32'd1);
`else
        run("s6", 1'b0, 1'b0);
        chk("err off", 32'(o_err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
